// File: rtl/mc_controller.sv
// Multicycle ARM control unit: main FSM, ALU/flag decode, NZCV register, condition gating.
// Controls are registered per state (DP 4, LDR 5, STR 4, B 3 cycles); no backpressure.
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUControl
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWRITE, S_MEMWB,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH, S_UNKNOWN
  } state_t;

  typedef struct packed {
    logic       nextpc;
    logic       branch;
    logic       regw;
    logic       memw;
    logic       irwrite;
    logic       adrsrc;
    logic       aluop;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
  } ctrl_t;

  state_t     state;
  state_t     nxt;
  ctrl_t      ctrl;
  logic [3:0] flags;
  logic       condexreg;
  logic       condex;
  logic [1:0] flagw;
  logic [1:0] alucontrol;
  logic       pcs;

  function automatic ctrl_t ctrl_of(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.irwrite = 1'b1; c.nextpc = 1'b1;
        c.alusrca = 2'b01; c.alusrcb = 2'b10; c.resultsrc = 2'b10;
      end
      S_DECODE: begin
        c.alusrca = 2'b01; c.alusrcb = 2'b10; c.resultsrc = 2'b10;
      end
      S_MEMADR:   c.alusrcb = 2'b01;
      S_MEMREAD:  c.adrsrc = 1'b1;
      S_MEMWRITE: begin c.adrsrc = 1'b1; c.memw = 1'b1; end
      S_MEMWB:    begin c.resultsrc = 2'b01; c.regw = 1'b1; end
      S_EXECUTER: c.aluop = 1'b1;
      S_EXECUTEI: begin c.aluop = 1'b1; c.alusrcb = 2'b01; end
      S_ALUWB:    c.regw = 1'b1;
      S_BRANCH: begin
        c.alusrca = 2'b10; c.alusrcb = 2'b01; c.resultsrc = 2'b10; c.branch = 1'b1;
      end
      default:    c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    nxt = S_FETCH;
    case (state)
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b00:   nxt = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b01:   nxt = S_MEMADR;
          2'b10:   nxt = S_BRANCH;
          default: nxt = S_UNKNOWN;
        endcase
      end
      S_MEMADR:   nxt = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  nxt = S_MEMWB;
      S_EXECUTER: nxt = S_ALUWB;
      S_EXECUTEI: nxt = S_ALUWB;
      default:    nxt = S_FETCH;
    endcase
  end

  // Controls for the coming state are registered alongside it, so outputs come straight from flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
      ctrl  <= ctrl_of(S_FETCH);
    end else begin
      state <= nxt;
      ctrl  <= ctrl_of(nxt);
    end
  end

  always_comb begin
    alucontrol = 2'b00;
    flagw      = 2'b00;
    if (ctrl.aluop) begin
      case (Funct[4:1])
        4'b0100: alucontrol = 2'b00;
        4'b0010: alucontrol = 2'b01;
        4'b0000: alucontrol = 2'b10;
        4'b1100: alucontrol = 2'b11;
        default: alucontrol = 2'b00;
      endcase
      flagw[1] = Funct[0];
      flagw[0] = Funct[0] & ~alucontrol[1];
    end
  end

  // flags = {N,Z,C,V}
  always_comb begin
    condex = 1'b0;
    case (Cond)
      4'b0000: condex = flags[2];
      4'b0001: condex = ~flags[2];
      4'b0010: condex = flags[1];
      4'b0011: condex = ~flags[1];
      4'b0100: condex = flags[3];
      4'b0101: condex = ~flags[3];
      4'b0110: condex = flags[0];
      4'b0111: condex = ~flags[0];
      4'b1000: condex = flags[1] & ~flags[2];
      4'b1001: condex = ~flags[1] | flags[2];
      4'b1010: condex = (flags[3] == flags[0]);
      4'b1011: condex = (flags[3] != flags[0]);
      4'b1100: condex = ~flags[2] & (flags[3] == flags[0]);
      4'b1101: condex = flags[2] | (flags[3] != flags[0]);
      4'b1110: condex = 1'b1;
      default: condex = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags     <= 4'b0000;
      condexreg <= 1'b0;
    end else begin
      if (flagw[1] & condex) flags[3:2] <= ALUFlags[3:2];
      if (flagw[0] & condex) flags[1:0] <= ALUFlags[1:0];
      condexreg <= condex;
    end
  end

  // Write-back gates on the condition captured a cycle earlier, i.e. against pre-update flags.
  assign pcs        = ((Rd == 4'b1111) & ctrl.regw) | ctrl.branch;
  assign PCWrite    = (pcs & condexreg) | ctrl.nextpc;
  assign RegWrite   = ctrl.regw & condexreg;
  assign MemWrite   = ctrl.memw & condexreg;
  assign IRWrite    = ctrl.irwrite;
  assign AdrSrc     = ctrl.adrsrc;
  assign ALUSrcA    = ctrl.alusrca;
  assign ALUSrcB    = ctrl.alusrcb;
  assign ResultSrc  = ctrl.resultsrc;
  assign ImmSrc     = Op;
  assign RegSrc     = {(Op == 2'b01), (Op == 2'b10)};
  assign ALUControl = alucontrol;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench: per-instruction reference model queues expected control vectors, negedge monitor compares.
module tb_mc_controller;

  logic       clk, reset;
  logic [3:0] Cond, Rd, ALUFlags;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
  logic [1:0] RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;

  mc_controller dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl)
  );

  typedef enum {P_F, P_D, P_MA, P_MR, P_MW, P_MWB, P_XR, P_XI, P_WB, P_B, P_U} ph_t;

  logic [16:0] sb[$];
  logic [16:0] act;
  logic [3:0]  mflags;  // model NZCV
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  assign act = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA, ALUSrcB,
                ResultSrc, ImmSrc, ALUControl};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    {n, z, cf, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  function automatic logic [1:0] alu_of(input logic [5:0] f);
    logic [3:0] cmd;
    cmd = f[4:1];
    if (cmd == 4'b0010) return 2'b01;
    if (cmd == 4'b0000) return 2'b10;
    if (cmd == 4'b1100) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [16:0] exp_vec(input ph_t p, input logic [1:0] op,
                                          input logic [5:0] f, input logic [3:0] rd,
                                          input logic ok);
    logic pcw, memw, regw, irw, adr;
    logic [1:0] sa, sbb, rs, ac;
    {pcw, memw, regw, irw, adr} = '0;
    {sa, sbb, rs, ac} = '0;
    case (p)
      P_F:   begin pcw = 1; irw = 1; sa = 2'b01; sbb = 2'b10; rs = 2'b10; end
      P_D:   begin sa = 2'b01; sbb = 2'b10; rs = 2'b10; end
      P_MA:  sbb = 2'b01;
      P_MR:  adr = 1;
      P_MW:  begin adr = 1; memw = ok; end
      P_MWB: begin rs = 2'b01; regw = ok; pcw = ok && (rd == 4'hF); end
      P_XR:  ac = alu_of(f);
      P_XI:  begin sbb = 2'b01; ac = alu_of(f); end
      P_WB:  begin regw = ok; pcw = ok && (rd == 4'hF); end
      P_B:   begin sa = 2'b10; sbb = 2'b01; rs = 2'b10; pcw = ok; end
      default: ;
    endcase
    return {pcw, memw, regw, irw, adr, (op == 2'b01), (op == 2'b10), sa, sbb, rs, op, ac};
  endfunction

  always @(negedge clk) begin
    if (!reset && sb.size() > 0) begin
      logic [16:0] e;
      e = sb.pop_front();
      vectors++;
      if (act !== e) begin
        miscompares++;
        $display("FAIL ctrl_vec cyc=%0d got=%05h want=%05h", cyc, act, e);
      end
    end
  end

  task automatic check_reset_outputs(input string name);
    logic [16:0] e;
    e = exp_vec(P_F, Op, Funct, Rd, 1'b0);
    vectors++;
    if (act !== e) begin
      miscompares++;
      $display("FAIL %s got=%05h want=%05h", name, act, e);
    end
  endtask

  // Called at posedge+1 of the instruction's FETCH cycle; abort_at interrupts it with a reset.
  task automatic run_instr(input logic [3:0] c, input logic [1:0] op, input logic [5:0] f,
                           input logic [3:0] rd, input logic [3:0] aluf, input int abort_at);
    ph_t seq[$];
    logic ok;
    seq = {P_F, P_D};
    case (op)
      2'b00: begin seq.push_back(f[5] ? P_XI : P_XR); seq.push_back(P_WB); end
      2'b01: begin
        seq.push_back(P_MA);
        if (f[0]) begin seq.push_back(P_MR); seq.push_back(P_MWB); end
        else seq.push_back(P_MW);
      end
      2'b10: seq.push_back(P_B);
      default: seq.push_back(P_U);
    endcase
    ok = cond_holds(c, mflags);
    Cond = c; Op = op; Funct = f; Rd = rd;
    for (int i = 0; i < seq.size(); i++) begin
      if (i == abort_at) begin
        reset = 1'b1;
        mflags = 4'b0000;
        #1;
        check_reset_outputs("reset_mid_instr");
        @(posedge clk); #1;
        reset = 1'b0;
        return;
      end
      if (seq[i] == P_XR || seq[i] == P_XI) begin
        ALUFlags = aluf;
        if (ok && f[0]) begin
          mflags[3:2] = aluf[3:2];
          if (alu_of(f) inside {2'b00, 2'b01}) mflags[1:0] = aluf[1:0];
        end
      end else begin
        ALUFlags = 4'($urandom);
      end
      sb.push_back(exp_vec(seq[i], op, f, rd, ok));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [3:0] rc, rrd;
    logic [1:0] rop;
    logic [5:0] rf;
    logic [3:0] cmds[5];
    cmds[0] = 4'b0100; cmds[1] = 4'b0010; cmds[2] = 4'b0000; cmds[3] = 4'b1100; cmds[4] = 4'b0111;
    reset = 1'b1; Cond = 4'hE; Op = 2'b00; Funct = 6'd0; Rd = 4'd0; ALUFlags = 4'd0;
    mflags = 4'b0000;
    #3;
    check_reset_outputs("reset_state");
    @(posedge clk); #1;
    reset = 1'b0;

    run_instr(4'hE, 2'b00, 6'b001000, 4'd1, 4'b0000, -1);  // ADD
    run_instr(4'hE, 2'b01, 6'b011001, 4'd2, 4'b0000, -1);  // LDR
    run_instr(4'hE, 2'b01, 6'b011000, 4'd2, 4'b0000, -1);  // STR
    run_instr(4'hE, 2'b00, 6'b100101, 4'd3, 4'b0100, -1);  // SUBS -> Z
    run_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000, -1);  // BEQ taken
    run_instr(4'h1, 2'b10, 6'b000000, 4'd0, 4'b0000, -1);  // BNE not taken
    run_instr(4'hE, 2'b01, 6'b011001, 4'd4, 4'b0000, 4);   // LDR reset in MEMWB
    run_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000, -1);  // BEQ after clear: not taken
    run_instr(4'hE, 2'b00, 6'b000001, 4'd5, 4'b1011, -1);  // ANDS -> 1000
    run_instr(4'h4, 2'b10, 6'b000000, 4'd0, 4'b0000, -1);  // BMI taken
    run_instr(4'h2, 2'b10, 6'b000000, 4'd0, 4'b0000, -1);  // BCS not taken
    run_instr(4'hE, 2'b00, 6'b001000, 4'hF, 4'b0000, -1);  // ADD PC
    run_instr(4'hE, 2'b11, 6'b000000, 4'd0, 4'b0000, -1);  // UNKNOWN
    run_instr(4'hF, 2'b00, 6'b001001, 4'hF, 4'b1111, -1);  // never-condition

    for (int n = 0; n < 300; n++) begin
      rc  = 4'($urandom);
      rop = 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
      rf  = 6'($urandom);
      if (rop == 2'b00) rf[4:1] = cmds[$urandom_range(0, 4)];
      rrd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      run_instr(rc, rop, rf, rrd, 4'($urandom),
                ($urandom_range(0, 24) == 0) ? int'($urandom_range(1, 4)) : -1);
    end

    @(negedge clk); #1;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain got=%0d want=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
